// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline stage register with two-entry skid buffer, flush and saturating event counters
module pipe_skid_reg #(
  parameter int DATA_W = 64,
  parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}},
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic              main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic              in_fire, out_fire, to_skid;
  assign in_ready  = !skid_v_q && !rst;
  assign out_valid = main_v_q;
  assign out_data  = main_v_q ? main_q : FLUSH_VAL;
  assign occupancy = 2'(main_v_q) + 2'(skid_v_q);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  always_comb begin
    in_fire     = in_valid && in_ready;
    out_fire    = main_v_q && out_ready;
    to_skid     = main_v_q && !skid_v_q && in_fire && !out_fire;
    main_v_d    = flush ? 1'b0 : !main_v_q ? in_fire : skid_v_q ? 1'b1 : (in_fire || !out_fire);
    main_d      = flush ? FLUSH_VAL
                : !main_v_q ? (in_fire ? in_data : main_q)
                : skid_v_q ? (out_fire ? skid_q : main_q)
                : (in_fire && out_fire) ? in_data
                : out_fire ? FLUSH_VAL : main_q;
    skid_v_d    = flush ? 1'b0 : skid_v_q ? !out_fire : to_skid;
    skid_d      = flush ? FLUSH_VAL
                : skid_v_q ? (out_fire ? FLUSH_VAL : skid_q)
                : to_skid ? in_data : skid_q;
    stall_cnt_d = (main_v_q && !out_ready && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (flush && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_q      <= FLUSH_VAL;
      skid_q      <= FLUSH_VAL;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed scenarios plus a negedge scoreboard of accepted beats and counter model
module tb_pipe_skid_reg;
  localparam int DW = 16;
  localparam int CW = 4;
  localparam logic [DW-1:0] FV = 16'h0013;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0;
  logic [DW-1:0] in_data = '0, out_data;
  logic [1:0] occupancy;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int tests = 0, fails = 0;
  bit mon_en = 0;
  logic [DW-1:0] q[$];
  int m_stall = 0, m_flush = 0;
  pipe_skid_reg #(.DATA_W(DW), .FLUSH_VAL(FV), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  // Scoreboard: pop on out_fire, then flush drops everything, else push on in_fire
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        q.delete();
        m_stall = 0;
        m_flush = 0;
      end else begin
        tests++; if (occupancy !== 2'(q.size())) begin fails++; $display("FAIL sb_occ got=%0d exp=%0d t=%0t", occupancy, q.size(), $time); end
        tests++; if (out_valid !== (q.size() != 0)) begin fails++; $display("FAIL sb_out_valid got=%b exp=%b t=%0t", out_valid, q.size() != 0, $time); end
        tests++; if (in_ready !== (q.size() < 2)) begin fails++; $display("FAIL sb_in_ready got=%b exp=%b t=%0t", in_ready, q.size() < 2, $time); end
        tests++; if (stall_cnt !== CW'(m_stall)) begin fails++; $display("FAIL sb_stall_cnt got=%0d exp=%0d t=%0t", stall_cnt, m_stall, $time); end
        tests++; if (flush_cnt !== CW'(m_flush)) begin fails++; $display("FAIL sb_flush_cnt got=%0d exp=%0d t=%0t", flush_cnt, m_flush, $time); end
        if (q.size() != 0) begin
          tests++; if (out_data !== q[0]) begin fails++; $display("FAIL sb_data got=%h exp=%h t=%0t", out_data, q[0], $time); end
          if (out_ready) void'(q.pop_front());
        end else begin
          tests++; if (out_data !== FV) begin fails++; $display("FAIL sb_bubble got=%h exp=%h t=%0t", out_data, FV, $time); end
        end
        if (out_valid && !out_ready && m_stall < 15) m_stall++;
        if (flush && m_flush < 15) m_flush++;
        if (flush) q.delete();
        else if (in_valid && in_ready) q.push_back(in_data);
      end
    end
  end
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    rst = 1; in_valid = 0; out_ready = 0; flush = 0;
    step(); step();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    tests++; if (out_data !== FV) begin fails++; $display("FAIL rst_out_data got=%h exp=%h", out_data, FV); end
    tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    tests++; if (stall_cnt !== '0 || flush_cnt !== '0) begin fails++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    rst = 0; #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_in_ready got=%b exp=1", in_ready); end
    mon_en = 1;
  endtask
  task automatic test_stream();
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1; in_data = DW'(i);
      step();
      tests++; if (out_valid !== 1'b1 || out_data !== DW'(i)) begin fails++; $display("FAIL stream_beat%0d got=%b/%h exp=1/%h", i, out_valid, out_data, DW'(i)); end
      tests++; if (occupancy > 2'd1) begin fails++; $display("FAIL stream_occ got=%0d exp<=1", occupancy); end
    end
    in_valid = 0;
    step();
    tests++; if (out_valid !== 1'b0 || stall_cnt !== '0) begin fails++; $display("FAIL stream_end got=%b/%0d exp=0/0", out_valid, stall_cnt); end
  endtask
  task automatic test_backpressure();
    in_valid = 1; in_data = 16'hA; out_ready = 1;
    step();
    out_ready = 0; in_data = 16'hB;
    step();
    tests++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 16'hA) begin fails++; $display("FAIL bp_full got=%0d/%b/%h exp=2/0/a", occupancy, in_ready, out_data); end
    in_data = 16'hC;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (in_ready !== 1'b0 || out_data !== 16'hA) begin fails++; $display("FAIL bp_hold%0d got=%b/%h exp=0/a", i, in_ready, out_data); end
    end
    tests++; if (stall_cnt !== 4'd4) begin fails++; $display("FAIL bp_stall_cnt got=%0d exp=4", stall_cnt); end
    out_ready = 1;
    step();
    tests++; if (out_data !== 16'hB || occupancy !== 2'd1 || in_ready !== 1'b1) begin fails++; $display("FAIL bp_rel_b got=%h/%0d/%b exp=b/1/1", out_data, occupancy, in_ready); end
    step();
    tests++; if (out_data !== 16'hC || out_valid !== 1'b1) begin fails++; $display("FAIL bp_rel_c got=%h/%b exp=c/1", out_data, out_valid); end
    in_valid = 0;
    step();
    tests++; if (out_valid !== 1'b0 || stall_cnt !== 4'd4) begin fails++; $display("FAIL bp_end got=%b/%0d exp=0/4", out_valid, stall_cnt); end
  endtask
  task automatic test_flush();
    out_ready = 0; in_valid = 1; in_data = 16'hA;
    step();
    in_data = 16'hB;
    step();
    flush = 1; in_data = 16'hD;
    step();
    flush = 0; in_valid = 0;
    tests++; if (out_valid !== 1'b0 || out_data !== FV || occupancy !== 2'd0) begin fails++; $display("FAIL flush_clear got=%b/%h/%0d exp=0/%h/0", out_valid, out_data, occupancy, FV); end
    tests++; if (flush_cnt !== 4'd1 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_cnt got=%0d/%b exp=1/1", flush_cnt, in_ready); end
    tests++; if (stall_cnt !== 4'd6) begin fails++; $display("FAIL flush_stall_cnt got=%0d exp=6", stall_cnt); end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_dropped got=%b/%h exp=0", out_valid, out_data); end
    end
  endtask
  task automatic test_reset_mid();
    out_ready = 0; in_valid = 1; in_data = 16'hE;
    step();
    in_valid = 0; rst = 1;
    step();
    tests++; if (out_valid !== 1'b0 || out_data !== FV || occupancy !== 2'd0 || in_ready !== 1'b0) begin fails++; $display("FAIL rstmid_out got=%b/%h/%0d/%b exp=0/%h/0/0", out_valid, out_data, occupancy, in_ready, FV); end
    tests++; if (stall_cnt !== '0 || flush_cnt !== '0) begin fails++; $display("FAIL rstmid_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    rst = 0;
    step();
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_after got=%b/%b exp=1/0", in_ready, out_valid); end
  endtask
  task automatic test_saturate();
    out_ready = 0; in_valid = 1; in_data = 16'h55;
    step();
    in_valid = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14 || i == 15 || i == 20) begin
        tests++; if (stall_cnt !== CW'(i > 15 ? 15 : i)) begin fails++; $display("FAIL sat_stall%0d got=%0d exp=%0d", i, stall_cnt, i > 15 ? 15 : i); end
      end
    end
    out_ready = 1;
    step();
  endtask
  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = DW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 40) == 0);
      step();
    end
    flush = 0; in_valid = 0; out_ready = 1;
    step(); step(); step();
    tests++; if (occupancy !== 2'd0 || q.size() != 0) begin fails++; $display("FAIL rand_drain got=%0d/%0d exp=0/0", occupancy, q.size()); end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
